router_pkt_tx: RTL and testbench

//  Packet source for the router 1x3 input port: host loads payload bytes into a local buffer, then issues start.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_tx_buf.sv | 25 ++
 rtl/router_pkt_tx.sv | 132 +++++++++++++
 tb/tb_router_pkt_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router packet transmitter.
// Header layout is {len[5:0], dest[1:0]}; a payload is 1..63 bytes.
package router_pkg;

  localparam int LEN_W       = 6;
  localparam int DEST_W      = 2;
  localparam int MAX_PAYLOAD = 63;

  localparam logic [DEST_W-1:0] ADDR_ILLEGAL = 2'd3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                             input logic [DEST_W-1:0] dest);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: DEPTH x 8 storage with one write port and a registered read port.
// Reads of addresses at or beyond DEPTH return zero.
module router_tx_buf #(
  parameter int DEPTH = 63,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; contents survive reset and every
  // byte is rewritten before it is read, so a reset network would be wasted.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (int'(rd_addr) < DEPTH) rd_data <= mem[rd_addr];
    else                       rd_data <= '0;
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers host payload bytes, then sends
// header, payload and parity while honouring router busy. GAP_CYCLES must be >= 1.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN    = MAX_PAYLOAD,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic       inject_err,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       packet_valid,
  output logic       tx_busy,
  output logic       done,
  output logic       err_cfg,
  output logic       buf_full
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0]       state;
  logic [LEN_W-1:0] wr_cnt, rd_ptr, len, rd_addr;
  logic [7:0]       parity, gap_cnt, rd_data;
  logic             inj_q, buf_we, advance;

  assign buf_we = (state == ST_IDLE) && wr_en && !start && !buf_full;

  // advance: the byte on the wire is accepted and another payload byte follows it
  // NOTE: default first so every path assigns advance and no latch is inferred.
  always_comb begin
    advance = 1'b0;
    if (!busy) begin
      if (state == ST_HEADER)                         advance = 1'b1;
      else if (state == ST_PAYLOAD && rd_ptr != len)  advance = 1'b1;
    end
  end

  // Read one byte ahead so the next payload byte is ready at the accepting edge.
  assign rd_addr = advance ? rd_ptr + LEN_W'(1) : rd_ptr;

  router_tx_buf #(.DEPTH(MAX_LEN), .AW(LEN_W)) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_cnt),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      data_out     <= '0;
      packet_valid <= 1'b0;
      tx_busy      <= 1'b0;
      done         <= 1'b0;
      err_cfg      <= 1'b0;
      buf_full     <= 1'b0;
      wr_cnt       <= '0;
      rd_ptr       <= '0;
      len          <= '0;
      parity       <= '0;
      gap_cnt      <= '0;
      inj_q        <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dest == ADDR_ILLEGAL || wr_cnt == '0) begin
              err_cfg <= 1'b1;
            end else begin
              state        <= ST_HEADER;
              data_out     <= make_header(wr_cnt, dest);
              parity       <= make_header(wr_cnt, dest);
              packet_valid <= 1'b1;
              tx_busy      <= 1'b1;
              inj_q        <= inject_err;
              len          <= wr_cnt;
              rd_ptr       <= '0;
            end
          end else if (buf_we) begin
            wr_cnt   <= wr_cnt + LEN_W'(1);
            buf_full <= (wr_cnt + LEN_W'(1)) == LEN_MAX;
          end
        end
        ST_HEADER, ST_PAYLOAD: begin
          if (advance) begin
            state    <= ST_PAYLOAD;
            data_out <= rd_data;
            parity   <= parity ^ rd_data;
            rd_ptr   <= rd_ptr + LEN_W'(1);
          end else if (!busy) begin
            state        <= ST_PARITY;
            data_out     <= inj_q ? ~parity : parity;
            packet_valid <= 1'b0;
          end
        end
        ST_PARITY: begin
          if (!busy) begin
            state    <= ST_GAP;
            data_out <= '0;
            gap_cnt  <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= ST_IDLE;
            done     <= 1'b1;
            tx_busy  <= 1'b0;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            buf_full <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: cycle tables for the fixed scenarios,
// hand sequences for error/reset corners, and randomized packets against a stream model.
`timescale 1ns/1ps
module tb_router_pkt_tx;

  localparam int MAX_LEN    = 63;
  localparam int GAP_CYCLES = 2;

  logic       clk = 1'b0, reset = 1'b1;
  logic       wr_en = 1'b0, start = 1'b0, inject_err = 1'b0, busy = 1'b0;
  logic [7:0] wr_data = '0;
  logic [1:0] dest = '0;
  logic [7:0] data_out;
  logic       packet_valid, tx_busy, done, err_cfg, buf_full;

  router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .start        (start),
    .dest         (dest),
    .inject_err   (inject_err),
    .busy         (busy),
    .data_out     (data_out),
    .packet_valid (packet_valid),
    .tx_busy      (tx_busy),
    .done         (done),
    .err_cfg      (err_cfg),
    .buf_full     (buf_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] byte_q_t[$];
  byte_q_t mdl_buf;

  // One row per cycle after start: inputs (start/inj/busy) and expected outputs.
  typedef struct packed {
    logic       start;
    logic       inj;
    logic       busy;
    logic       pv;
    logic [7:0] data;
    logic       done;
    logic       txb;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic s, input logic i, input logic b, input logic pv,
                         input logic [7:0] d, input logic dn, input logic tb);
    vec_t v;
    v = '{start: s, inj: i, busy: b, pv: pv, data: d, done: dn, txb: tb};
    vecs.push_back(v);
  endtask

  // Host writes; the model keeps only the first MAX_LEN bytes.
  task automatic write_bytes(input byte_q_t q);
    foreach (q[i]) begin
      wr_en = 1'b1;
      wr_data = q[i];
      tick();
      if (mdl_buf.size() < MAX_LEN) mdl_buf.push_back(q[i]);
      check("buf_full", buf_full, (mdl_buf.size() == MAX_LEN));
      if ($urandom_range(3) == 0) begin
        wr_en = 1'b0;
        tick();
      end
    end
    wr_en = 1'b0;
  endtask

  // Start a packet from the model buffer and check every wire cycle, the gap and done.
  task automatic run_packet(input logic [1:0] d, input logic inj, input int busy_pct,
                            input logic wr_with_start, input string tag);
    logic [8:0] exp[$];
    logic [7:0] hdr, par;
    int idx, cyc, budget;
    hdr = {6'(mdl_buf.size()), d};
    par = hdr;
    exp.push_back({1'b1, hdr});
    foreach (mdl_buf[i]) begin
      par = par ^ mdl_buf[i];
      exp.push_back({1'b1, mdl_buf[i]});
    end
    exp.push_back({1'b0, inj ? ~par : par});
    budget = exp.size() * 6;

    start = 1'b1; dest = d; inject_err = inj;
    wr_en = wr_with_start; wr_data = 8'h77;
    tick();
    start = 1'b0; wr_en = 1'b0;

    idx = 0;
    cyc = 0;
    while (idx < exp.size()) begin
      busy = (cyc < budget) && ($urandom_range(99) < busy_pct);
      inject_err = 1'($urandom);
      dest = 2'($urandom);
      start = ($urandom_range(7) == 0);
      wr_en = ($urandom_range(3) == 0);
      wr_data = 8'($urandom);
      check({tag, " stream"}, {tx_busy, err_cfg, done, packet_valid, data_out},
            {1'b1, 1'b0, 1'b0, exp[idx]});
      if (!busy) idx++;
      tick();
      cyc++;
    end
    start = 1'b0; wr_en = 1'b0;

    for (int g = 0; g < GAP_CYCLES; g++) begin
      busy = 1'($urandom);
      check({tag, " gap"}, {tx_busy, done, packet_valid, data_out}, {1'b1, 1'b0, 1'b0, 8'h00});
      tick();
    end
    check({tag, " done"}, {tx_busy, done, packet_valid, data_out, buf_full},
          {1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    busy = 1'b0;
    tick();
    check({tag, " after done"}, {done, tx_busy}, 2'b00);
    mdl_buf.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t q;
    int      plen;

    repeat (2) @(posedge clk);
    #1;
    check("reset state", {data_out, packet_valid, tx_busy, done, err_cfg, buf_full}, '0);
    reset = 1'b0;
    tick();

    // dest=1, payload 11 22 33: header 0x0D, parity 0x0D (0xF2 inverted)
    add_vec(1, 0, 0, 1, 8'h0D, 0, 1);
    add_vec(0, 0, 0, 1, 8'h11, 0, 1);
    add_vec(0, 0, 0, 1, 8'h22, 0, 1);
    add_vec(0, 0, 0, 1, 8'h33, 0, 1);
    add_vec(0, 0, 0, 0, 8'h0D, 0, 1);
    add_vec(0, 0, 0, 0, 8'h00, 0, 1);
    add_vec(0, 0, 0, 0, 8'h00, 0, 1);
    add_vec(0, 0, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 0, 0, 8'h00, 0, 0);
    add_vec(1, 0, 0, 1, 8'h0D, 0, 1);
    add_vec(0, 0, 0, 1, 8'h11, 0, 1);
    add_vec(0, 0, 1, 1, 8'h22, 0, 1);
    add_vec(0, 0, 1, 1, 8'h22, 0, 1);
    add_vec(0, 0, 1, 1, 8'h22, 0, 1);
    add_vec(0, 0, 0, 1, 8'h22, 0, 1);
    add_vec(0, 0, 0, 1, 8'h33, 0, 1);
    add_vec(0, 0, 0, 0, 8'h0D, 0, 1);
    add_vec(0, 0, 0, 0, 8'h00, 0, 1);
    add_vec(0, 0, 0, 0, 8'h00, 0, 1);
    add_vec(0, 0, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 0, 0, 8'h00, 0, 0);
    add_vec(1, 1, 0, 1, 8'h0D, 0, 1);
    add_vec(0, 1, 0, 1, 8'h11, 0, 1);
    add_vec(0, 1, 0, 1, 8'h22, 0, 1);
    add_vec(0, 1, 0, 1, 8'h33, 0, 1);
    add_vec(0, 1, 1, 0, 8'hF2, 0, 1);
    add_vec(0, 1, 0, 0, 8'hF2, 0, 1);
    add_vec(0, 1, 0, 0, 8'h00, 0, 1);
    add_vec(0, 1, 0, 0, 8'h00, 0, 1);
    add_vec(0, 1, 0, 0, 8'h00, 1, 0);
    add_vec(0, 1, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].start) begin
        q = {8'h11, 8'h22, 8'h33};
        write_bytes(q);
        mdl_buf.delete();
        start = 1'b1; dest = 2'd1; inject_err = vecs[i].inj;
        tick();
        start = 1'b0; inject_err = 1'b0;
      end
      busy = vecs[i].busy;
      check($sformatf("vec%0d", i), {tx_busy, done, packet_valid, data_out},
            {vecs[i].txb, vecs[i].done, vecs[i].pv, vecs[i].data});
      tick();
    end
    busy = 1'b0;

    // Rejected starts: empty buffer, then illegal destination with data kept.
    start = 1'b1; dest = 2'd0;
    tick();
    start = 1'b0;
    check("err empty", {err_cfg, packet_valid, tx_busy}, 3'b100);
    tick();
    check("err empty width", err_cfg, 1'b0);
    q = {8'hA5};
    write_bytes(q);
    start = 1'b1; dest = 2'd3;
    tick();
    start = 1'b0;
    check("err dest3", {err_cfg, packet_valid, tx_busy}, 3'b100);
    tick();
    check("err dest3 width", err_cfg, 1'b0);
    run_packet(2'd0, 1'b0, 0, 1'b1, "after err");

    // Full buffer: 64 writes, last dropped; 63-byte packet to dest 2.
    q.delete();
    for (int i = 1; i <= 64; i++) q.push_back(8'(i));
    write_bytes(q);
    run_packet(2'd2, 1'b0, 25, 1'b0, "full");

    // Asynchronous reset in the middle of the payload.
    q = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    write_bytes(q);
    start = 1'b1; dest = 2'd2;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre-reset payload", {tx_busy, packet_valid, data_out}, {1'b1, 1'b1, 8'hC3});
    #2 reset = 1'b1;
    #1;
    check("async reset", {data_out, packet_valid, tx_busy, done, buf_full}, '0);
    #2 reset = 1'b0;
    mdl_buf.delete();
    tick();
    q = {8'h5A, 8'h3C, 8'h96};
    write_bytes(q);
    run_packet(2'd1, 1'b1, 30, 1'b0, "post reset");

    // Randomized packets.
    for (int n = 0; n < 25; n++) begin
      plen = (n % 5 == 0) ? $urandom_range(55, 66) : $urandom_range(1, 12);
      q.delete();
      repeat (plen) q.push_back(8'($urandom));
      write_bytes(q);
      run_packet(2'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 60),
                 1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
